// File: rtl/serial_add_sequencer_pkg.sv
// State encoding and default width for the bit-serial add sequencer.
package add_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/half_adder_cell.sv
// Single half adder; two of these plus an OR make the serial full-add bit.
// Combinational, no backpressure.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder, LSB first, done strobe WIDTH+1 cycles after start.
// No queueing: start is honoured only in IDLE/DONE; ena=0 freezes everything.
module serial_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry_q;

    logic             accept;
    logic             in_run;
    logic             last_bit;
    logic             s0;
    logic             c0;
    logic             bit_sum;
    logic             c1;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_run   = (state_q == ST_RUN);
    assign last_bit = in_run && (cnt_q == CW'(WIDTH - 1));

    half_adder_cell u_ha_ab (
        .a (a_sr[0]),
        .b (b_sr[0]),
        .s (s0),
        .c (c0)
    );

    half_adder_cell u_ha_cin (
        .a (s0),
        .b (carry_q),
        .s (bit_sum),
        .c (c1)
    );

    assign carry_next = c0 | c1;
    assign res_next   = {bit_sum, res_sr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Encoding 2'd3 is unreachable; the default arm steers it back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (ena) begin
            if (accept) begin
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end else if (in_run) begin
                a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr  <= res_next[WIDTH-1:1];
                carry_q <= carry_next;
                cnt_q   <= cnt_q + CW'(1);
                if (last_bit) begin
                    sum  <= res_next;
                    cout <= carry_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a result scoreboard.
module tb_serial_add_sequencer;
    import add_seq_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Scoreboard consumer: a done cycle completes on the edge where ena is high.
    always @(negedge clk) begin
        #1;
        if (rst_n === 1'b1 && done === 1'b1 && ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sb_result", 32'({cout, sum}), 32'(e));
                last_res = e;
            end
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic do_add(input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [W:0] e;
        e = model(aa, bb);
        a = aa; b = bb; start = 1'b1;
        exp_q.push_back(e);
        cyc();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int i = 1; i <= W; i++) begin
            check("busy_run", 32'(busy), 32'd1);
            check("done_in_run", 32'(done), 32'd0);
            check("sum_stable", 32'({cout, sum}), 32'(last_res));
            cyc();
        end
        check("done_latency", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        cyc();
        check("done_cleared", 32'(done), 32'd0);
        check("idle_after", 32'(dut.state_q), 32'(ST_IDLE));
        check("sum_hold", 32'({cout, sum}), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0;
        cyc(); cyc();
        check("rst_sum", 32'({cout, sum}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        cyc();

        do_add(4'd5, 4'd3);
        do_add(4'd15, 4'd1);
        do_add(4'd15, 4'd15);
        do_add(4'd0, 4'd0);

        // start during RUN must be ignored
        a = 4'd6; b = 4'd7; start = 1'b1;
        exp_q.push_back(model(4'd6, 4'd7));
        cyc();
        start = 1'b0;
        cyc();
        a = 4'd1; b = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        check("ign_done", 32'(done), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("ign_no_second_done", 32'(done), 32'd0);
        end
        check("ign_sum", 32'({cout, sum}), 32'd13);

        // ena low for three cycles after two bits
        a = 4'd5; b = 4'd3; start = 1'b1;
        exp_q.push_back(model(4'd5, 4'd3));
        cyc();
        start = 1'b0;
        cyc(); cyc();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ena_busy", 32'(busy), 32'd1);
            check("ena_cnt_frozen", 32'(dut.cnt_q), 32'd2);
            cyc();
        end
        ena = 1'b1;
        check("ena_busy_resume", 32'(busy), 32'd1);
        cyc();
        check("ena_busy_resume2", 32'(busy), 32'd1);
        cyc();
        check("ena_done_late", 32'(done), 32'd1);
        cyc();
        check("ena_sum", 32'({cout, sum}), 32'd8);

        // pending done is held while ena is low
        a = 4'd2; b = 4'd2; start = 1'b1;
        exp_q.push_back(model(4'd2, 4'd2));
        cyc();
        start = 1'b0;
        for (int i = 0; i < W; i++) cyc();
        check("hold_done0", 32'(done), 32'd1);
        ena = 1'b0;
        cyc();
        check("hold_done1", 32'(done), 32'd1);
        cyc();
        check("hold_done2", 32'(done), 32'd1);
        ena = 1'b1;
        cyc();
        check("hold_done_release", 32'(done), 32'd0);

        // reset mid-run aborts the operation
        a = 4'd5; b = 4'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        last_res = '0;
        check("abort_sum", 32'({cout, sum}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        do_add(4'd2, 4'd9);

        // start held high: back-to-back operations
        a = 4'd4; b = 4'd4; start = 1'b1;
        exp_q.push_back(model(4'd4, 4'd4));
        cyc();
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= W; i++) begin
                check("b2b_busy", 32'(busy), 32'd1);
                cyc();
            end
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_busy_low", 32'(busy), 32'd0);
            if (k < 2) exp_q.push_back(model(4'd4, 4'd4));
            else start = 1'b0;
            cyc();
        end
        check("b2b_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("b2b_sum", 32'({cout, sum}), 32'd8);

        cyc(); cyc();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
